// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit bidirectional uio pad bus among NREQ requesters,
// with per-grant beat cap and an idle turnaround gap whenever the pad direction flips.
module uio_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ*8-1:0] wdata,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   beat,
  output logic [7:0]        rdata,
  output logic [NREQ-1:0]   rvalid,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, TURN, ACTIVE} state_t;

  state_t          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   lastWin_q;
  logic            odir_q;
  logic            curDir_q;
  logic [3:0]      holdCnt_q;
  logic [1:0]      turnCnt_q;
  logic [7:0]      rdata_q;
  logic [NREQ-1:0] rvalid_q;

  logic [IW-1:0]   winner;
  logic            winValid;
  logic [IW:0]     candSum;
  logic [NREQ-1:0] winHot;
  logic            winDir;
  logic [NREQ-1:0] ownerHot;
  logic            reqOwner;
  logic [7:0]      ownerWdata;
  logic            beatNow;
  logic            activeWrite;

  // Circular search starting just after the previous winner gives round-robin fairness.
  always_comb begin
    winner   = '0;
    winValid = 1'b0;
    candSum  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      candSum = {1'b0, lastWin_q} + (IW+1)'(i);
      if (candSum >= (IW+1)'(NREQ)) candSum = candSum - (IW+1)'(NREQ);
      if (!winValid && req[candSum[IW-1:0]]) begin
        winner   = candSum[IW-1:0];
        winValid = 1'b1;
      end
    end
  end

  always_comb begin
    ownerWdata = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q == IW'(k)) ownerWdata = wdata[8*k +: 8];
    end
  end

  assign winHot      = NREQ'(1) << winner;
  assign winDir      = |(dir & winHot);
  assign ownerHot    = NREQ'(1) << owner_q;
  assign reqOwner    = |(req & ownerHot);
  assign beatNow     = (state_q == ACTIVE) && ena && reqOwner;
  assign activeWrite = (state_q == ACTIVE) && ena && odir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      lastWin_q <= IW'(NREQ-1);
      odir_q    <= 1'b0;
      curDir_q  <= 1'b0;
      holdCnt_q <= '0;
      turnCnt_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= '0;
    end else begin
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (ena && winValid) begin
            owner_q   <= winner;
            odir_q    <= winDir;
            holdCnt_q <= '0;
            turnCnt_q <= '0;
            state_q   <= (winDir != curDir_q) ? TURN : ACTIVE;
          end
        end
        TURN: begin
          if (!ena) begin
            state_q   <= IDLE;
            lastWin_q <= owner_q;
          end else if (turnCnt_q == 2'(TURNAROUND-1)) begin
            // The gap is complete, so the bus direction is committed even if the owner has left.
            curDir_q <= odir_q;
            if (reqOwner) begin
              state_q <= ACTIVE;
            end else begin
              state_q   <= IDLE;
              lastWin_q <= owner_q;
            end
          end else begin
            turnCnt_q <= turnCnt_q + 2'd1;
          end
        end
        ACTIVE: begin
          if (!beatNow) begin
            state_q   <= IDLE;
            lastWin_q <= owner_q;
          end else begin
            holdCnt_q <= holdCnt_q + 4'd1;
            if (!odir_q) begin
              rdata_q  <= uio_in;
              rvalid_q <= ownerHot;
            end
            if (holdCnt_q == 4'(MAX_HOLD-1)) begin
              state_q   <= IDLE;
              lastWin_q <= owner_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uio_oe  = activeWrite ? 8'hFF : 8'h00;
  assign uio_out = activeWrite ? ownerWdata : 8'h00;
  assign gnt     = (state_q != IDLE) ? ownerHot : '0;
  assign beat    = beatNow ? ownerHot : '0;
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: one task per scenario, each with hand-computed
// expectations for grants, beats, pad enables and read capture.
module tb_uio_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [3:0]  gnt;
  logic [3:0]  beat;
  logic [7:0]  rdata;
  logic [3:0]  rvalid;
  logic        busy;

  int testsRun;
  int testsFailed;

  uio_bus_arbiter #(.NREQ(4), .MAX_HOLD(4), .TURNAROUND(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .gnt(gnt), .beat(beat),
    .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] r, input logic [3:0] d);
    ena = e;
    req = r;
    dir = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    wdata  = '0;
    uio_in = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    wdata = 32'hFFFF_FFFF;
    #1;
    testsRun++;
    if (uio_oe !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_oe: got %h want 00", uio_oe); end
    testsRun++;
    if (uio_out !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_out: got %h want 00", uio_out); end
    testsRun++;
    if ({gnt, beat, rvalid} !== 12'h000) begin
      testsFailed++; $display("[TB] FAIL reset_onehots: gnt=%b beat=%b rvalid=%b want all 0", gnt, beat, rvalid);
    end
    testsRun++;
    if ({busy, rdata} !== 9'h000) begin testsFailed++; $display("[TB] FAIL reset_busy_rdata: got %b/%h want 0/00", busy, rdata); end
  endtask

  task automatic test_write_grant();
    logic [3:0] expGnt  [0:7];
    logic [7:0] expOe   [0:7];
    logic [3:0] expBeat [0:7];
    logic       expBusy [0:7];
    expGnt  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    expOe   = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    expBeat = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1};
    expBusy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    doReset();
    wdata[7:0] = 8'hA5;
    applyStimulus(1'b1, 4'b0001, 4'b0001);
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) nextCycle();
      testsRun++;
      if (gnt !== expGnt[c]) begin testsFailed++; $display("[TB] FAIL write_gnt c%0d: got %b want %b", c+1, gnt, expGnt[c]); end
      testsRun++;
      if (uio_oe !== expOe[c]) begin testsFailed++; $display("[TB] FAIL write_oe c%0d: got %h want %h", c+1, uio_oe, expOe[c]); end
      testsRun++;
      if (beat !== expBeat[c]) begin testsFailed++; $display("[TB] FAIL write_beat c%0d: got %b want %b", c+1, beat, expBeat[c]); end
      testsRun++;
      if (busy !== expBusy[c]) begin testsFailed++; $display("[TB] FAIL write_busy c%0d: got %b want %b", c+1, busy, expBusy[c]); end
      if (expOe[c] == 8'hFF) begin
        testsRun++;
        if (uio_out !== 8'hA5) begin testsFailed++; $display("[TB] FAIL write_out c%0d: got %h want a5", c+1, uio_out); end
      end
    end
    applyStimulus(1'b1, 4'b0000, 4'b0001);
  endtask

  task automatic test_read_round_robin();
    int         order [0:4];
    int         g;
    logic [3:0] hot;
    logic [7:0] lastIn;
    order  = '{0, 1, 2, 3, 0};
    lastIn = 8'h00;
    doReset();
    // Requester 3 writes first so the bus is in output direction before the read grants.
    wdata[31:24] = 8'hC3;
    applyStimulus(1'b1, 4'b1000, 4'b1000);
    nextCycle();
    testsRun++;
    if (gnt !== 4'b1000 || uio_oe !== 8'h00) begin testsFailed++; $display("[TB] FAIL rr_setup_turn: gnt=%b oe=%h want 1000/00", gnt, uio_oe); end
    nextCycle();
    testsRun++;
    if (uio_oe !== 8'hFF || uio_out !== 8'hC3) begin testsFailed++; $display("[TB] FAIL rr_setup_write: oe=%h out=%h want ff/c3", uio_oe, uio_out); end
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    #1;
    testsRun++;
    if (uio_oe !== 8'hFF || gnt !== 4'b1000) begin testsFailed++; $display("[TB] FAIL rr_latched_dir: oe=%h gnt=%b want ff/1000", uio_oe, gnt); end
    repeat (4) nextCycle();
    testsRun++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rr_setup_idle: busy=%b gnt=%b want 0/0000", busy, gnt); end
    for (int n = 0; n < 5; n++) begin
      g   = order[n];
      hot = 4'b0001 << g;
      nextCycle();
      if (n == 0) begin
        testsRun++;
        if (gnt !== hot || uio_oe !== 8'h00 || beat !== 4'b0000 || busy !== 1'b1) begin
          testsFailed++; $display("[TB] FAIL rr_turn: gnt=%b oe=%h beat=%b busy=%b want %b/00/0000/1", gnt, uio_oe, beat, busy, hot);
        end
        nextCycle();
      end
      for (int b = 0; b < 4; b++) begin
        if (b > 0) nextCycle();
        testsRun++;
        if (gnt !== hot || beat !== hot || uio_oe !== 8'h00) begin
          testsFailed++; $display("[TB] FAIL rr_beat g%0d b%0d: gnt=%b beat=%b oe=%h want %b/%b/00", g, b, gnt, beat, uio_oe, hot, hot);
        end
        testsRun++;
        if (rvalid !== ((b > 0) ? hot : 4'b0000)) begin
          testsFailed++; $display("[TB] FAIL rr_rvalid g%0d b%0d: got %b want %b", g, b, rvalid, (b > 0) ? hot : 4'b0000);
        end
        if (b > 0) begin
          testsRun++;
          if (rdata !== lastIn) begin testsFailed++; $display("[TB] FAIL rr_rdata g%0d b%0d: got %h want %h", g, b, rdata, lastIn); end
        end
        uio_in = (n == 0 && b == 0) ? 8'h3C : 8'(8'h40 + n*16 + b);
        lastIn = uio_in;
      end
      nextCycle();
      testsRun++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || rvalid !== hot || rdata !== lastIn) begin
        testsFailed++; $display("[TB] FAIL rr_idle g%0d: gnt=%b busy=%b rvalid=%b rdata=%h want 0000/0/%b/%h", g, gnt, busy, rvalid, rdata, hot, lastIn);
      end
    end
    applyStimulus(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic test_direction_change();
    logic [3:0] expGnt  [0:9];
    logic [7:0] expOe   [0:9];
    logic [3:0] expBeat [0:9];
    logic       expBusy [0:9];
    expGnt  = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h4};
    expOe   = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    expBeat = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h4, 4'h4};
    expBusy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    doReset();
    wdata[15:8] = 8'h5A;
    applyStimulus(1'b1, 4'b0010, 4'b0010);
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) nextCycle();
      testsRun++;
      if (gnt !== expGnt[c] || beat !== expBeat[c] || busy !== expBusy[c]) begin
        testsFailed++; $display("[TB] FAIL dirchg_ctl c%0d: gnt=%b beat=%b busy=%b want %b/%b/%b", c+1, gnt, beat, busy, expGnt[c], expBeat[c], expBusy[c]);
      end
      testsRun++;
      if (uio_oe !== expOe[c]) begin testsFailed++; $display("[TB] FAIL dirchg_oe c%0d: got %h want %h", c+1, uio_oe, expOe[c]); end
      if (c == 2) begin
        testsRun++;
        if (uio_out !== 8'h5A) begin testsFailed++; $display("[TB] FAIL dirchg_out: got %h want 5a", uio_out); end
        applyStimulus(1'b1, 4'b0110, 4'b0010);
      end
    end
    applyStimulus(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic test_ena_drop();
    doReset();
    wdata[7:0] = 8'h11;
    applyStimulus(1'b1, 4'b0011, 4'b0001);
    repeat (3) nextCycle();
    testsRun++;
    if (uio_oe !== 8'hFF || beat !== 4'b0001 || uio_out !== 8'h11) begin
      testsFailed++; $display("[TB] FAIL ena_before: oe=%h beat=%b out=%h want ff/0001/11", uio_oe, beat, uio_out);
    end
    ena = 1'b0;
    #1;
    testsRun++;
    if (uio_oe !== 8'h00 || beat !== 4'b0000) begin testsFailed++; $display("[TB] FAIL ena_force: oe=%h beat=%b want 00/0000", uio_oe, beat); end
    nextCycle();
    testsRun++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin testsFailed++; $display("[TB] FAIL ena_idle: busy=%b gnt=%b want 0/0000", busy, gnt); end
    nextCycle();
    testsRun++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin testsFailed++; $display("[TB] FAIL ena_noarb: busy=%b gnt=%b want 0/0000", busy, gnt); end
    ena = 1'b1;
    nextCycle();
    testsRun++;
    if (gnt !== 4'b0010 || busy !== 1'b1 || uio_oe !== 8'h00) begin
      testsFailed++; $display("[TB] FAIL ena_next: gnt=%b busy=%b oe=%h want 0010/1/00", gnt, busy, uio_oe);
    end
    applyStimulus(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic test_async_reset();
    doReset();
    wdata[23:16] = 8'h99;
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    repeat (2) nextCycle();
    testsRun++;
    if (uio_oe !== 8'hFF || gnt !== 4'b0100) begin testsFailed++; $display("[TB] FAIL arst_before: oe=%h gnt=%b want ff/0100", uio_oe, gnt); end
    #2;
    rst = 1'b1;
    #1;
    testsRun++;
    if (uio_oe !== 8'h00 || gnt !== 4'b0000 || beat !== 4'b0000 || busy !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL arst_immediate: oe=%h gnt=%b beat=%b busy=%b want 00/0000/0000/0", uio_oe, gnt, beat, busy);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    nextCycle();
    testsRun++;
    if (gnt !== 4'b0001 || beat !== 4'b0001) begin testsFailed++; $display("[TB] FAIL arst_first_winner: gnt=%b beat=%b want 0001/0001", gnt, beat); end
    applyStimulus(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic test_req_drop();
    int beatCount;
    beatCount = 0;
    doReset();
    wdata[23:16] = 8'h77;
    applyStimulus(1'b1, 4'b0100, 4'b1100);
    repeat (2) nextCycle();
    if (beat[2] === 1'b1) beatCount++;
    testsRun++;
    if (uio_out !== 8'h77 || gnt !== 4'b0100) begin testsFailed++; $display("[TB] FAIL drop_active: out=%h gnt=%b want 77/0100", uio_out, gnt); end
    req = 4'b1101;
    nextCycle();
    if (beat[2] === 1'b1) beatCount++;
    nextCycle();
    req = 4'b1001;
    #1;
    testsRun++;
    if (beat !== 4'b0000) begin testsFailed++; $display("[TB] FAIL drop_cycle_beat: got %b want 0000", beat); end
    if (beat[2] === 1'b1) beatCount++;
    testsRun++;
    if (beatCount != 2) begin testsFailed++; $display("[TB] FAIL drop_beat_count: got %0d want 2", beatCount); end
    nextCycle();
    testsRun++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL drop_idle: gnt=%b busy=%b want 0000/0", gnt, busy); end
    nextCycle();
    testsRun++;
    if (gnt !== 4'b1000 || beat !== 4'b1000 || uio_oe !== 8'hFF) begin
      testsFailed++; $display("[TB] FAIL drop_next_winner: gnt=%b beat=%b oe=%h want 1000/1000/ff", gnt, beat, uio_oe);
    end
    applyStimulus(1'b1, 4'b0000, 4'b0000);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst    = 1'b1;
    ena    = 1'b0;
    req    = '0;
    dir    = '0;
    wdata  = '0;
    uio_in = '0;
    test_reset();
    test_write_grant();
    test_read_round_robin();
    test_direction_change();
    test_ena_drop();
    test_async_reset();
    test_req_drop();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
